// File: rtl/adc_pkt_pkg.sv
// adc_pkt_pkg: shared types and constants for the ADC packetizer.
//   pkt_state_t - read-side FSM state
//   HDR_LEN     - application header length in bytes
//   MAGIC       - header byte 0
//   VERSION     - header byte 1
//   LEN_W       - width of a frame length (holds up to 1472)
//   hdr_byte()  - header byte for a given index
package adc_pkt_pkg;

  typedef enum logic [1:0] {IDLE, HDR, PAY} pkt_state_t;

  localparam int unsigned HDR_LEN = 8;
  localparam logic [7:0]  MAGIC   = 8'hAD;
  localparam logic [7:0]  VERSION = 8'h01;
  localparam int unsigned LEN_W   = 11;

  // Multi-byte fields are big-endian.
  function automatic logic [7:0] hdr_byte(input logic [2:0]       idx,
                                          input logic [15:0]      seq,
                                          input logic [LEN_W-1:0] len,
                                          input logic [15:0]      drop);
    logic [7:0] b;
    case (idx)
      3'd0:    b = MAGIC;
      3'd1:    b = VERSION;
      3'd2:    b = seq[15:8];
      3'd3:    b = seq[7:0];
      3'd4:    b = {{(16 - LEN_W){1'b0}}, len[LEN_W-1:8]};
      3'd5:    b = len[7:0];
      3'd6:    b = drop[15:8];
      default: b = drop[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk_i, rst_ni      - clock, async active-low reset
//   wr_i, wdata_i      - write strobe and data (ignored when full)
//   rd_i               - pop strobe (ignored when empty)
//   rdata_o            - head entry, valid whenever !empty_o
//   count_o            - current occupancy
//   full_o, empty_o    - status flags
// Depth must be a power of two, at least 2.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       rd_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign wr_en = wr_i & ~full_o;
  assign rd_en = rd_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (rd_en) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/adc_packetizer.sv
// adc_packetizer: stores whole frames from the ADC buffer byte stream and replays
// each one as an AXI4-Stream byte stream behind an 8-byte application header.
//   clk, rstn                       - clock, async active-low reset
//   s_data, s_valid, s_last         - input byte stream, no backpressure
//   m_axis_tdata/tvalid/tready/tlast - output AXI4-Stream (registered)
//   drop_cnt                        - frames dropped since reset (saturating)
//   seq_num                         - frames fully emitted since reset (wrapping)
module adc_packetizer
  import adc_pkt_pkg::*;
#(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned MAX_PAYLOAD = 1472,
  parameter int unsigned LEN_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] drop_cnt,
  output logic [15:0] seq_num
);

  localparam int unsigned PCW = $clog2(DEPTH + 1);
  localparam int unsigned LCW = $clog2(LEN_DEPTH + 1);
  localparam int unsigned LUW = LCW + 1;
  // A frame may start only while the FIFO holds no more than this many bytes.
  localparam logic [PCW-1:0] FILL_LIMIT = PCW'(DEPTH - MAX_PAYLOAD);

  // FIFO interfaces
  logic             pay_wr, pay_rd, pay_full, pay_empty;
  logic [7:0]       pay_rdata;
  logic [PCW-1:0]   pay_count;
  logic             len_wr, len_rd, len_full, len_empty;
  logic [LEN_W-1:0] len_wdata, len_rdata;
  logic [LCW-1:0]   len_count;

  // Write side
  logic             in_frame_q, in_frame_d;
  logic             keep_q, keep_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d;
  logic [15:0]      drop_q, drop_d;
  logic             keep_now, room_ok, len_ok;
  logic [LEN_W-1:0] cnt_now, cnt_next;
  logic [LUW-1:0]   len_used;

  // Read side
  pkt_state_t       state_q, state_d;
  logic [2:0]       hdr_idx_q, hdr_idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] sent_q, sent_d;
  logic [15:0]      drop_snap_q, drop_snap_d;
  logic [15:0]      seq_q, seq_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             hs;

  logic unused_flags;
  assign unused_flags = pay_full ^ pay_empty ^ len_full;

  sync_fifo #(
    .Width(8),
    .Depth(DEPTH)
  ) u_pay_fifo (
    .clk_i  (clk),
    .rst_ni (rstn),
    .wr_i   (pay_wr),
    .wdata_i(s_data),
    .rd_i   (pay_rd),
    .rdata_o(pay_rdata),
    .count_o(pay_count),
    .full_o (pay_full),
    .empty_o(pay_empty)
  );

  sync_fifo #(
    .Width(LEN_W),
    .Depth(LEN_DEPTH)
  ) u_len_fifo (
    .clk_i  (clk),
    .rst_ni (rstn),
    .wr_i   (len_wr),
    .wdata_i(len_wdata),
    .rd_i   (len_rd),
    .rdata_o(len_rdata),
    .count_o(len_count),
    .full_o (len_full),
    .empty_o(len_empty)
  );

  // The frame currently being emitted still holds a slot until its last byte goes out,
  // so LEN_DEPTH bounds every committed-but-unsent frame.
  assign len_used = {1'b0, len_count} + {{LCW{1'b0}}, (state_q != IDLE)};
  assign len_ok   = (len_used < LUW'(LEN_DEPTH));
  assign room_ok  = (pay_count <= FILL_LIMIT);

  always_comb begin
    in_frame_d = in_frame_q;
    keep_d     = keep_q;
    wcnt_d     = wcnt_q;
    drop_d     = drop_q;
    pay_wr     = 1'b0;
    len_wr     = 1'b0;
    // Accept/drop is decided on the first byte and held for the rest of the frame.
    keep_now   = in_frame_q ? keep_q : (room_ok & len_ok);
    cnt_now    = in_frame_q ? wcnt_q : '0;
    cnt_next   = cnt_now;

    if (s_valid) begin
      if (keep_now && (cnt_now < LEN_W'(MAX_PAYLOAD))) begin
        pay_wr   = 1'b1;
        cnt_next = cnt_now + LEN_W'(1);
      end
      if (!in_frame_q && !keep_now && (drop_q != 16'hFFFF)) begin
        drop_d = drop_q + 16'd1;
      end
      if (s_last) begin
        in_frame_d = 1'b0;
        len_wr     = keep_now;
      end else begin
        in_frame_d = 1'b1;
        keep_d     = keep_now;
        wcnt_d     = cnt_next;
      end
    end
    len_wdata = cnt_next;
  end

  assign hs = tvalid_q & m_axis_tready;

  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    len_d       = len_q;
    sent_d      = sent_q;
    drop_snap_d = drop_snap_q;
    seq_d       = seq_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    pay_rd      = 1'b0;
    len_rd      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!len_empty) begin
          len_rd    = 1'b1;
          len_d     = len_rdata;
          hdr_idx_d = 3'd0;
          tdata_d   = MAGIC;
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (hs) begin
          // Drop count is captured when the header actually starts leaving.
          if (hdr_idx_q == 3'd0) drop_snap_d = drop_q;
          if (hdr_idx_q == 3'(HDR_LEN - 1)) begin
            state_d = PAY;
            pay_rd  = 1'b1;
            tdata_d = pay_rdata;
            sent_d  = LEN_W'(1);
            tlast_d = (len_q == LEN_W'(1));
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
            tdata_d   = hdr_byte(hdr_idx_q + 3'd1, seq_q, len_q, drop_snap_q);
          end
        end
      end
      PAY: begin
        if (hs) begin
          if (tlast_q) begin
            tdata_d  = 8'h00;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            seq_d    = seq_q + 16'd1;
            state_d  = IDLE;
          end else begin
            pay_rd  = 1'b1;
            tdata_d = pay_rdata;
            sent_d  = sent_q + LEN_W'(1);
            tlast_d = ((sent_q + LEN_W'(1)) == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_frame_q  <= 1'b0;
      keep_q      <= 1'b0;
      wcnt_q      <= '0;
      drop_q      <= '0;
      state_q     <= IDLE;
      hdr_idx_q   <= '0;
      len_q       <= '0;
      sent_q      <= '0;
      drop_snap_q <= '0;
      seq_q       <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      in_frame_q  <= in_frame_d;
      keep_q      <= keep_d;
      wcnt_q      <= wcnt_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      len_q       <= len_d;
      sent_q      <= sent_d;
      drop_snap_q <= drop_snap_d;
      seq_q       <= seq_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign drop_cnt      = drop_q;
  assign seq_num       = seq_q;

endmodule

// File: tb/tb_adc_packetizer.sv
// Directed self-checking bench for adc_packetizer (DEPTH 2048, LEN_DEPTH 4).
module tb_adc_packetizer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [15:0] drop_cnt;
  logic [15:0] seq_num;

  int n_cmp = 0;
  int n_bad = 0;
  int stab_err = 0;
  bit rnd_ready = 1'b0;
  bit ready_val = 1'b0;

  logic [7:0] obytes[$];
  bit         olast[$];
  logic [7:0] exp1 [12];

  always #4 clk = ~clk;

  adc_packetizer #(
    .DEPTH      (2048),
    .MAX_PAYLOAD(1472),
    .LEN_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .drop_cnt     (drop_cnt),
    .seq_num      (seq_num)
  );

  always @(posedge clk) begin
    #1;
    m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Values at the negedge are exactly what the next posedge samples.
  always @(negedge clk) begin
    if (rstn && m_axis_tvalid && m_axis_tready) begin
      obytes.push_back(m_axis_tdata);
      olast.push_back(m_axis_tlast);
    end
  end

  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic       prev_l = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata != prev_d || m_axis_tlast != prev_l))
        stab_err++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_b(input int i);
    if (i < obytes.size()) return obytes[i];
    return 8'hxx;
  endfunction

  task automatic do_reset();
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    obytes.delete();
    olast.delete();
  endtask

  task automatic send_frame(input int n, input logic [7:0] start, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      s_valid = 1'b1;
      s_data  = start + 8'(i) * step;
      s_last  = (i == n - 1);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Bounded wait for n output bytes, then a settle period to catch extra bytes.
  task automatic wait_out(input int n, input int budget, input string tag);
    int k = 0;
    while (obytes.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    check_eq(tag, 32'(obytes.size()), 32'(n));
  endtask

  task automatic check_hdr(input string tag, input int base, input int seq, input int len,
                           input int drop);
    check_eq({tag, "_magic"}, 32'(get_b(base)), 32'h0000_00AD);
    check_eq({tag, "_ver"}, 32'(get_b(base + 1)), 32'h0000_0001);
    check_eq({tag, "_seq"}, 32'({get_b(base + 2), get_b(base + 3)}), 32'(seq));
    check_eq({tag, "_len"}, 32'({get_b(base + 4), get_b(base + 5)}), 32'(len));
    check_eq({tag, "_drop"}, 32'({get_b(base + 6), get_b(base + 7)}), 32'(drop));
  endtask

  task automatic check_tlast(input string tag, input int exp_idx);
    int nl = 0;
    int li = -1;
    for (int i = 0; i < olast.size(); i++) begin
      if (olast[i]) begin
        nl++;
        li = i;
      end
    end
    check_eq({tag, "_tlast_n"}, 32'(nl), 32'd1);
    check_eq({tag, "_tlast_at"}, 32'(li), 32'(exp_idx));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    exp1 = '{8'hAD, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00,
             8'h11, 8'h22, 8'h33, 8'h44};

    // Test 1: single 4-byte frame, tready high
    ready_val = 1'b1;
    do_reset();
    check_eq("rst_tdata", 32'(m_axis_tdata), 32'h0);
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    check_eq("rst_tlast", 32'(m_axis_tlast), 32'h0);
    check_eq("rst_drop", 32'(drop_cnt), 32'h0);
    check_eq("rst_seq", 32'(seq_num), 32'h0);
    send_frame(4, 8'h11, 8'h11);
    wait_out(12, 100, "t1_count");
    for (int i = 0; i < 12; i++) check_eq($sformatf("t1_byte%0d", i), 32'(get_b(i)), 32'(exp1[i]));
    check_tlast("t1", 11);
    check_eq("t1_seq", 32'(seq_num), 32'd1);

    // Test 2: same frame with random tready
    rnd_ready = 1'b1;
    do_reset();
    send_frame(4, 8'h11, 8'h11);
    wait_out(12, 400, "t2_count");
    for (int i = 0; i < 12; i++) check_eq($sformatf("t2_byte%0d", i), 32'(get_b(i)), 32'(exp1[i]));
    check_tlast("t2", 11);
    check_eq("t2_stable", 32'(stab_err), 32'd0);
    rnd_ready = 1'b0;

    // Test 3: length queue overflow with tready low
    ready_val = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) send_frame(1, 8'hA0 + 8'(k), 8'h00);
    check_eq("t3_drop", 32'(drop_cnt), 32'd1);
    check_eq("t3_no_out", 32'(obytes.size()), 32'd0);
    ready_val = 1'b1;
    wait_out(36, 200, "t3_count");
    for (int k = 0; k < 4; k++) begin
      check_hdr($sformatf("t3_f%0d", k), 9 * k, k, 1, 1);
      check_eq($sformatf("t3_f%0d_pay", k), 32'(get_b(9 * k + 8)), 32'(8'hA0 + 8'(k)));
    end
    check_eq("t3_seq", 32'(seq_num), 32'd4);

    // Test 4: oversize frame is truncated to MAX_PAYLOAD
    do_reset();
    send_frame(1482, 8'h00, 8'h01);
    wait_out(1480, 3000, "t4_count");
    check_hdr("t4", 0, 0, 1472, 0);
    bad = 0;
    for (int i = 0; i < 1472; i++) if (get_b(8 + i) !== 8'(i)) bad++;
    check_eq("t4_payload_errs", 32'(bad), 32'd0);
    check_tlast("t4", 1479);
    check_eq("t4_drop", 32'(drop_cnt), 32'd0);

    // Test 5: payload FIFO free-space drop
    ready_val = 1'b0;
    do_reset();
    send_frame(1472, 8'h00, 8'h01);
    send_frame(4, 8'h55, 8'h01);
    check_eq("t5_drop", 32'(drop_cnt), 32'd1);
    ready_val = 1'b1;
    wait_out(1480, 3000, "t5_count1");
    check_eq("t5_f1_len", 32'({get_b(4), get_b(5)}), 32'h05C0);
    send_frame(2, 8'h77, 8'h01);
    wait_out(1490, 200, "t5_count3");
    check_hdr("t5_f3", 1480, 1, 2, 1);
    check_eq("t5_f3_pay0", 32'(get_b(1488)), 32'h77);
    check_eq("t5_f3_pay1", 32'(get_b(1489)), 32'h78);

    // Test 6: reset during payload of frame 2
    do_reset();
    send_frame(4, 8'h11, 8'h11);
    send_frame(20, 8'h40, 8'h01);
    for (int k = 0; k < 200 && obytes.size() < 25; k++) @(negedge clk);
    check_eq("t6_reached_pay", 32'(obytes.size() >= 25), 32'd1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("t6_tdata", 32'(m_axis_tdata), 32'h0);
    check_eq("t6_tvalid", 32'(m_axis_tvalid), 32'h0);
    check_eq("t6_tlast", 32'(m_axis_tlast), 32'h0);
    check_eq("t6_seq", 32'(seq_num), 32'h0);
    check_eq("t6_drop", 32'(drop_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    obytes.delete();
    olast.delete();
    send_frame(3, 8'h90, 8'h01);
    wait_out(11, 100, "t6_count");
    check_hdr("t6_next", 0, 0, 3, 0);
    check_eq("t6_next_pay0", 32'(get_b(8)), 32'h90);
    check_eq("all_stable", 32'(stab_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
